// File: rtl/bus_if_ctrl.sv
// Memory access sequencer for one pipeline stage: same-cycle SPM accesses and a
// request/grant/ready bus FSM. Optional bus-ready watchdog enabled by BUS_TIMEOUT_EN.
module bus_if_ctrl #(
  parameter logic [2:0] SPM_REGION = 3'd3
`ifdef BUS_TIMEOUT_EN
  , parameter logic [7:0] TIMEOUT  = 8'd255
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] addr,
  input  logic        as_,
  input  logic        rw,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        busy,
  input  logic [31:0] spm_rd_data,
  output logic [29:0] spm_addr,
  output logic        spm_as_,
  output logic        spm_rw,
  output logic [31:0] spm_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_,
  input  logic        bus_grnt_,
  output logic        bus_req_,
  output logic [29:0] bus_addr,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [31:0] bus_wr_data,
  output logic        bus_err,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ACCESS = 2'd2, WAIT = 2'd3} state_e;

  state_e      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_as_q, bus_as_d;
  logic [29:0] bus_addr_q, bus_addr_d;
  logic        bus_rw_q, bus_rw_d;
  logic [31:0] bus_wr_data_q, bus_wr_data_d;
  logic [31:0] rd_buf_q, rd_buf_d;
  logic        valid, hit_spm;
`ifdef BUS_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`endif

  assign hit_spm     = (addr[29:27] == SPM_REGION);
  assign valid       = !as_ && !flush;
  assign spm_addr    = addr;
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;
  assign bus_req_    = bus_req_q;
  assign bus_as_     = bus_as_q;
  assign bus_addr    = bus_addr_q;
  assign bus_rw      = bus_rw_q;
  assign bus_wr_data = bus_wr_data_q;
  assign state_o     = state_q;

  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_as_d      = bus_as_q;
    bus_addr_d    = bus_addr_q;
    bus_rw_d      = bus_rw_q;
    bus_wr_data_d = bus_wr_data_q;
    rd_buf_d      = rd_buf_q;
    rd_data       = 32'd0;
    busy          = 1'b0;
    spm_as_       = 1'b1;
    bus_err       = 1'b0;
`ifdef BUS_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid && hit_spm) begin
          spm_as_ = 1'b0;
          rd_data = spm_rd_data;
        end else if (valid) begin
          busy          = 1'b1;
          bus_addr_d    = addr;
          bus_rw_d      = rw;
          bus_wr_data_d = wr_data;
          bus_req_d     = 1'b0;
          state_d       = REQ;
        end
      end
      REQ: begin
        busy = 1'b1;
        if (!bus_grnt_) begin
          bus_as_d = 1'b0;
          state_d  = ACCESS;
`ifdef BUS_TIMEOUT_EN
          cnt_d    = 8'd0;
`endif
        end
      end
      ACCESS: begin
        // Strobe is only ever low for the first ACCESS cycle.
        bus_as_d = 1'b1;
        if (!bus_rdy_) begin
          rd_data   = bus_rd_data;
          rd_buf_d  = bus_rd_data;
          bus_req_d = 1'b1;
          state_d   = stall ? WAIT : IDLE;
        end else begin
          busy = 1'b1;
`ifdef BUS_TIMEOUT_EN
          if (cnt_q == TIMEOUT) begin
            bus_err   = 1'b1;
            busy      = 1'b0;
            bus_req_d = 1'b1;
            rd_buf_d  = 32'd0;
            state_d   = stall ? WAIT : IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`endif
        end
      end
      WAIT: begin
        rd_data = rd_buf_q;
        if (!stall) state_d = IDLE;
      end
    endcase
    // Stage-facing outputs stay quiet while reset is held, whatever the state.
    if (reset) begin
      rd_data = 32'd0;
      busy    = 1'b0;
      spm_as_ = 1'b1;
      bus_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      bus_req_q     <= 1'b1;
      bus_as_q      <= 1'b1;
      bus_addr_q    <= 30'd0;
      bus_rw_q      <= 1'b1;
      bus_wr_data_q <= 32'd0;
      rd_buf_q      <= 32'd0;
`ifdef BUS_TIMEOUT_EN
      cnt_q         <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_as_q      <= bus_as_d;
      bus_addr_q    <= bus_addr_d;
      bus_rw_q      <= bus_rw_d;
      bus_wr_data_q <= bus_wr_data_d;
      rd_buf_q      <= rd_buf_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

endmodule
